elbeth_mdu: RTL and testbench

//  Parametrised iterative multiply/divide unit, sequential companion to elbeth_alu.

---
 rtl/elbeth_mdu_pkg.sv | 44 ++++
 rtl/elbeth_mdu_signfix.sv | 13 +
 rtl/elbeth_mdu.sv | 195 +++++++++++++++++++
 tb/tb_elbeth_mdu.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_mdu_pkg.sv
// elbeth_mdu_pkg: op encodings, FSM states and
// op-class helpers shared by the multiply/divide unit.
package elbeth_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL   = 3'd0,
    MDU_MULH  = 3'd1,
    MDU_MULHU = 3'd2,
    MDU_RSVD  = 3'd3,
    MDU_DIV   = 3'd4,
    MDU_DIVU  = 3'd5,
    MDU_REM   = 3'd6,
    MDU_REMU  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mdu_state_e;

  // MUL is treated as unsigned: its low half
  // does not depend on operand signedness.
  function automatic logic is_signed(
    input logic [2:0] op
  );
    return (op == MDU_MULH) ||
           (op == MDU_DIV)  ||
           (op == MDU_REM);
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return op[2];
  endfunction

  function automatic logic is_rem(
    input logic [2:0] op
  );
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/elbeth_mdu_signfix.sv
// elbeth_mdu_signfix: conditional two's-complement negate.
// val_i in, neg_i selects -val_i, val_o out.
module elbeth_mdu_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/elbeth_mdu.sv
// elbeth_mdu: iterative mul/div, one bit per clock.
// in_valid/in_ready request, out_valid/out_ready result, flush abort.
module elbeth_mdu
  import elbeth_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]    pfix;
  logic [WIDTH-1:0] dsel, dfix;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ok;
  logic [W2-1:0]    div_next;
  logic             b_zero, ovf;

  elbeth_mdu_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .val_i (data_a),
    .neg_i (is_signed(op) & data_a[WIDTH-1]),
    .val_o (mag_a)
  );

  elbeth_mdu_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .val_i (data_b),
    .neg_i (is_signed(op) & data_b[WIDTH-1]),
    .val_o (mag_b)
  );

  elbeth_mdu_signfix #(.WIDTH(W2)) u_fix_p (
    .val_i (prod_q),
    .neg_i (neg_q),
    .val_o (pfix)
  );

  // prod_q holds {remainder, quotient} in
  // divide mode.
  assign dsel = is_rem(op_q) ?
    prod_q[W2-1:WIDTH] : prod_q[WIDTH-1:0];

  elbeth_mdu_signfix #(.WIDTH(WIDTH)) u_fix_d (
    .val_i (dsel),
    .neg_i (neg_q),
    .val_o (dfix)
  );

  // shift-add: add multiplicand into the upper
  // half when the lsb is set, then shift right.
  assign mul_sum =
    {1'b0, prod_q[W2-1:WIDTH]} +
    (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next =
    {mul_sum, prod_q[WIDTH-1:1]};

  // restoring divide: shift in the next dividend
  // bit, keep the difference if non-negative.
  assign div_sh   = prod_q[W2-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_next = {
    div_ok ? div_diff[WIDTH-1:0]
           : div_sh[WIDTH-1:0],
    prod_q[WIDTH-2:0],
    div_ok
  };

  assign b_zero = (data_b == '0);
  assign ovf = ((op == MDU_DIV) ||
                (op == MDU_REM)) &&
               (data_a == SMIN) &&
               (data_b == '1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    dz_d     = dz_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d  = op;
            cnt_d = '0;
            dz_d  = 1'b0;
            neg_d = 1'b0;
            if (is_signed(op)) begin
              neg_d = is_rem(op) ?
                data_a[WIDTH-1] :
                data_a[WIDTH-1] ^ data_b[WIDTH-1];
            end
            if (op == MDU_RSVD) begin
              result_d = '0;
              state_d  = DONE;
            end else if (is_div(op) && b_zero) begin
              dz_d     = 1'b1;
              result_d = is_rem(op) ? data_a : '1;
              state_d  = DONE;
            end else if (ovf) begin
              result_d = is_rem(op) ? '0 : data_a;
              state_d  = DONE;
            end else begin
              opnd_d  = is_div(op) ? mag_b : mag_a;
              prod_d  = {{WIDTH{1'b0}},
                         is_div(op) ? mag_a : mag_b};
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_d = DONE;
            case (op_q)
              MDU_MUL:
                result_d = pfix[WIDTH-1:0];
              MDU_MULH, MDU_MULHU:
                result_d = pfix[W2-1:WIDTH];
              default:
                result_d = dfix;
            endcase
          end else begin
            cnt_d  = cnt_q + CW'(1);
            prod_d = is_div(op_q) ?
              div_next : mul_next;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_elbeth_mdu.sv
// tb_elbeth_mdu: scoreboard bench for elbeth_mdu
// at WIDTH=32, directed and random operations.
module tb_elbeth_mdu;
  import elbeth_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         div_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];

  elbeth_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(
    input logic [2:0]   o,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    exp_t e;
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = o[2] && (b == 0);
    e.r = '0;
    case (o)
      3'd0: begin
        p = 64'(a) * 64'(b);
        e.r = p[31:0];
      end
      3'd1: begin
        p = 64'(sa * sb);
        e.r = p[63:32];
      end
      3'd2: begin
        p = 64'(a) * 64'(b);
        e.r = p[63:32];
      end
      3'd4: e.r = (b == 0) ? '1 : 32'(sa / sb);
      3'd5: e.r = (b == 0) ? '1 : a / b;
      3'd6: e.r = (b == 0) ? a : 32'(sa % sb);
      3'd7: e.r = (b == 0) ? a : a % b;
      default: e.r = '0;
    endcase
    return e;
  endfunction

  task automatic send(
    input logic [2:0]   o,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input exp_t         e
  );
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_ready in_ready=%0b want 1",
               in_ready);
    end
    exp_q.push_back(e);
    op = o; data_a = a; data_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    op = 3'($urandom);
    data_a = $urandom;
    data_b = $urandom;
  endtask

  task automatic recv(
    output logic [W-1:0] r,
    output logic         dz,
    output int           lat
  );
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL recv_timeout out_valid=0 want 1");
    end
    r = result; dz = div_zero;
    lat = cyc - acc_cyc;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pop_cmp(
    input string        nm,
    input logic [W-1:0] r,
    input logic         dz
  );
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      if (r !== e.r || dz !== e.dz) begin
        errors++;
        $display("FAIL %s got %h/%0b want %h/%0b",
                 nm, r, dz, e.r, e.dz);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        result !== '0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset rdy=%0b vld=%0b r=%h dz=%0b want 1 0 0 0",
               in_ready, out_valid, result, div_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic dz; int lat;
    send(3'd0, 32'd3, 32'd4, '{32'd12, 1'b0});
    recv(r, dz, lat);
    pop_cmp("mul_3x4", r, dz);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL mul_latency got %0d want %0d",
               lat, W + 1);
    end
    send(3'd1, '1, '1, '{32'h0, 1'b0});
    recv(r, dz, lat);
    pop_cmp("mulh_m1", r, dz);
    send(3'd2, '1, '1, '{32'hFFFFFFFE, 1'b0});
    recv(r, dz, lat);
    pop_cmp("mulhu_max", r, dz);
  endtask

  task automatic test_div();
    logic [W-1:0] r; logic dz; int lat;
    send(3'd4, -32'sd7, 32'd2, '{32'hFFFFFFFD, 1'b0});
    recv(r, dz, lat);
    pop_cmp("div_m7_2", r, dz);
    send(3'd6, -32'sd7, 32'd2, '{32'hFFFFFFFF, 1'b0});
    recv(r, dz, lat);
    pop_cmp("rem_m7_2", r, dz);
    send(3'd5, 32'd7, 32'd2, '{32'd3, 1'b0});
    recv(r, dz, lat);
    pop_cmp("divu_7_2", r, dz);
  endtask

  task automatic test_special();
    logic [W-1:0] r; logic dz; int lat;
    send(3'd4, 32'd5, 32'd0, '{32'hFFFFFFFF, 1'b1});
    recv(r, dz, lat);
    pop_cmp("div_by0", r, dz);
    // lat 0: valid in the cycle right after the accept edge
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL div_by0_latency got %0d want 0", lat);
    end
    send(3'd7, 32'd5, 32'd0, '{32'd5, 1'b1});
    recv(r, dz, lat);
    pop_cmp("remu_by0", r, dz);
    send(3'd3, 32'd9, 32'd9, '{32'd0, 1'b0});
    recv(r, dz, lat);
    pop_cmp("reserved", r, dz);
  endtask

  task automatic test_overflow_hold();
    logic [W-1:0] r; logic dz; int lat;
    int bad = 0;
    send(3'd4, 32'h80000000, '1, '{32'h80000000, 1'b0});
    recv(r, dz, lat);
    pop_cmp("div_ovf", r, dz);
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL div_ovf_latency got %0d want 0", lat);
    end
    out_ready = 1'b0;
    send(3'd6, 32'h80000000, '1, '{32'h0, 1'b0});
    recv(r, dz, lat);
    pop_cmp("rem_ovf", r, dz);
    in_valid = 1'b1; op = 3'd0;
    data_a = 32'd77; data_b = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (result !== 32'h0 || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || div_zero !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable bad_cycles=%0d want 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release vld=%0b rdy=%0b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    send(3'd0, 32'd123, 32'd456, model(3'd0, 32'd123, 32'd456));
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle rdy=%0b vld=%0b want 1 0",
               in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_novalid got %0d want 0", seen);
    end
    exp_q.delete();
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] r; logic dz; int lat;
    send(3'd5, 32'd100, 32'd7, '{32'd14, 1'b0});
    recv(r, dz, lat);
    pop_cmp("divu_100_7", r, dz);
    send(3'd5, 32'd200, 32'd7, '{32'd28, 1'b0});
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        result !== '0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid rdy=%0b vld=%0b r=%h dz=%0b want 1 0 0 0",
               in_ready, out_valid, result, div_zero);
    end
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, a, b; logic dz; int lat;
    logic [2:0] o;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = 32'($urandom_range(1, 50));
      if (i % 5 == 0) b = '0;
      if (i % 7 == 0) begin
        a = 32'h80000000; b = '1;
      end
      send(o, a, b, model(o, a, b));
      recv(r, dz, lat);
      pop_cmp("random", r, dz);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_overflow_hold();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

endmodule
